memwriteback: RTL



---
 rtl/cpu_pkg.sv | 37 +++
 rtl/dbus_master.sv | 86 ++++++++
 rtl/memwriteback.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the memory/writeback stage: FSM states, dispatch opcodes
// and the registered writeback bundle handed to fetchdecode.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    BUS_WAIT = 2'd2
  } mwb_state_t;

  localparam logic [2:0] OP_ALU     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_STORE   = 3'd2;
  localparam logic [2:0] OP_DBLOAD  = 3'd3;
  localparam logic [2:0] OP_DBSTORE = 3'd4;

  typedef struct packed {
    logic        write_reg;
    logic        mem_to_reg;
    logic        bus_to_reg;
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_bus_t;

  // Illegal flag combinations resolve by fixed priority: load, store, bus.
  function automatic logic [2:0] mwb_decode(input logic mem_read,
                                            input logic mem_write,
                                            input logic bus_to_reg,
                                            input logic bus_write);
    if (mem_read)        return OP_LOAD;
    else if (mem_write)  return OP_STORE;
    else if (bus_to_reg) return OP_DBLOAD;
    else if (bus_write)  return OP_DBSTORE;
    else                 return OP_ALU;
  endfunction

endpackage

// File: rtl/dbus_master.sv
// Data-bus master: holds a request stable until ack or timeout and reports
// completion, timeout and read data back to the stage FSM.
module dbus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        ack_i,
  input  logic [15:0] rdata_i,
  output logic        req_o,
  output logic        we_o,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] rdata_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    err_o   = 1'b0;
    if (req_q) begin
      // Ack wins over a timeout landing on the same edge.
      if (ack_i) begin
        done_o = 1'b1;
      end else if (cnt_q == TW'(TIMEOUT - 1)) begin
        err_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (done_o || err_o) begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        cnt_d   = '0;
      end
    end else if (start_i) begin
      req_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_i;

endmodule

// File: rtl/memwriteback.sv
// Memory access + writeback stage: ALU writeback, data-memory load/store,
// or a handshaked data-bus transfer, with a stall while a load/bus op is open.
module memwriteback
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT     = 2,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic [15:0] iALUResult,
  input  logic [15:0] iStoreData,
  input  logic        iWriteReg,
  input  logic [3:0]  iWriteRegAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iBustoReg,
  input  logic        iBusWrite,
  output logic [15:0] oMemAddr,
  output logic [15:0] oMemWData,
  output logic        oMemRe,
  output logic        oMemWe,
  input  logic [15:0] iMemRData,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [15:0] oBusAddr,
  output logic [15:0] oBusWData,
  input  logic        iBusAck,
  input  logic [15:0] iBusRData,
  output logic        oBusErr,
  output logic        oWriteReg,
  output logic        oMemtoReg,
  output logic        oBustoReg,
  output logic [3:0]  oWriteRegAddr,
  output logic [15:0] oWriteRegData,
  output logic        oStall
);

  localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  mwb_state_t    state_q, state_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [3:0]    rd_q, rd_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic          stall_q, stall_d;
  logic          bus_err_q, bus_err_d;
  wb_bus_t       wb_q, wb_d;

  logic [2:0]    op;
  logic          bus_start;
  logic          bus_done;
  logic          bus_err;
  logic [15:0]   bus_rdata;

  assign op = mwb_decode(iMemRead, iMemWrite, iBustoReg, iBusWrite);

  dbus_master #(
    .TIMEOUT (BUS_TIMEOUT)
  ) u_dbus (
    .clk_i   (iclk),
    .rst_ni  (irst_n),
    .start_i (bus_start),
    .we_i    (op == OP_DBSTORE),
    .addr_i  (iALUResult),
    .wdata_i (iStoreData),
    .ack_i   (iBusAck),
    .rdata_i (iBusRData),
    .req_o   (oBusReq),
    .we_o    (oBusWe),
    .addr_o  (oBusAddr),
    .wdata_o (oBusWData),
    .done_o  (bus_done),
    .err_o   (bus_err),
    .rdata_o (bus_rdata)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (op == OP_LOAD)                              state_d = MEM_WAIT;
        else if (op == OP_DBLOAD || op == OP_DBSTORE)   state_d = BUS_WAIT;
      end
      MEM_WAIT: if (mcnt_q == '0)         state_d = IDLE;
      BUS_WAIT: if (bus_done || bus_err)  state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    mcnt_d      = mcnt_q;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    bus_start   = 1'b0;
    bus_err_d   = 1'b0;
    wb_d        = '0;
    stall_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        rd_d = iWriteRegAddr;
        case (op)
          OP_LOAD: begin
            mem_re_d   = 1'b1;
            mem_addr_d = iALUResult;
            mcnt_d     = MW'(MEM_LAT - 1);
          end
          OP_STORE: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = iALUResult;
            mem_wdata_d = iStoreData;
          end
          OP_DBLOAD, OP_DBSTORE: bus_start = 1'b1;
          OP_ALU: begin
            wb_d.write_reg = iWriteReg && (iWriteRegAddr != 4'd0);
            wb_d.addr      = iWriteRegAddr;
            wb_d.data      = iALUResult;
          end
          default: ;
        endcase
      end
      MEM_WAIT: begin
        if (mcnt_q == '0) begin
          wb_d.mem_to_reg = (rd_q != 4'd0);
          wb_d.addr       = rd_q;
          wb_d.data       = iMemRData;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end
      BUS_WAIT: begin
        bus_err_d = bus_err;
        // A timed-out DbLoad still writes back zero so the register is known.
        if ((bus_done || bus_err) && !oBusWe) begin
          wb_d.bus_to_reg = (rd_q != 4'd0);
          wb_d.addr       = rd_q;
          wb_d.data       = bus_done ? bus_rdata : 16'h0000;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mcnt_q      <= '0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      stall_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      wb_q        <= '0;
    end else begin
      mcnt_q      <= mcnt_d;
      rd_q        <= rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      stall_q     <= stall_d;
      bus_err_q   <= bus_err_d;
      wb_q        <= wb_d;
    end
  end

  assign oMemAddr      = mem_addr_q;
  assign oMemWData     = mem_wdata_q;
  assign oMemRe        = mem_re_q;
  assign oMemWe        = mem_we_q;
  assign oBusErr       = bus_err_q;
  assign oStall        = stall_q;
  assign oWriteReg     = wb_q.write_reg;
  assign oMemtoReg     = wb_q.mem_to_reg;
  assign oBustoReg     = wb_q.bus_to_reg;
  assign oWriteRegAddr = wb_q.addr;
  assign oWriteRegData = wb_q.data;

endmodule
